// File: rtl/uart_transceiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_transceiver_if
//  Description : Byte-wide ready/valid handshake bundle for the UART
//                transmit and receive paths.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_transceiver_if;

    // Transmit path: user offers a byte, UART accepts when idle
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;

    // Receive path: UART presents a byte, user consumes it
    logic [7:0] data_out;
    logic       data_out_valid;
    logic       data_out_ready;

    // User side (CPU, bench) of the UART
    modport master (
        output data_in,
        output data_in_valid,
        input  data_in_ready,
        input  data_out,
        input  data_out_valid,
        output data_out_ready
    );

    // UART side
    modport slave (
        input  data_in,
        input  data_in_valid,
        output data_in_ready,
        output data_out,
        output data_out_valid,
        input  data_out_ready
    );

endinterface
`default_nettype wire

// File: rtl/uart_transceiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_transceiver
//  Description : Full-duplex 8N1 UART. Independent transmitter and receiver,
//                each with a byte-wide ready/valid handshake. The receiver
//                samples mid-bit after a 2-flop synchronizer.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_transceiver #(
    parameter int CLOCK_FREQ = 125_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  wire              clk,
    input  wire              reset,       // asynchronous, active low
    uart_transceiver_if.slave bus,
    input  wire              serial_in,
    output logic             serial_out
);

    // Clocks per bit and the half-bit offset used to land on bit centres
    localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
    localparam int SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
    localparam int CNT_W            = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SAMPLE_TIME - 1);

    // ------------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    tx_state_t        tx_state_q;
    logic [9:0]       tx_frame_q;
    logic [9:0]       tx_frame_d;
    logic [CNT_W-1:0] tx_cnt_q;
    logic [3:0]       tx_bit_q;
    logic             tx_ready_q;
    logic             serial_out_q;

    // Stop bit, payload LSB first, start bit
    assign tx_frame_d = {1'b1, bus.data_in, 1'b0};

    // TX FSM: the frame is held in a shift register so bit k sits at [0]
    // while serial_out drives it; serial_out is always a flop output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state_q   <= TX_IDLE;
            tx_frame_q   <= '1;
            tx_cnt_q     <= '0;
            tx_bit_q     <= '0;
            tx_ready_q   <= 1'b1;
            serial_out_q <= 1'b1;
        end else begin
            case (tx_state_q)
                TX_IDLE: begin
                    tx_cnt_q <= '0;
                    tx_bit_q <= '0;
                    if (bus.data_in_valid) begin
                        tx_frame_q   <= tx_frame_d;
                        serial_out_q <= tx_frame_d[0];
                        tx_ready_q   <= 1'b0;
                        tx_state_q   <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (tx_cnt_q == BIT_LAST) begin
                        tx_cnt_q <= '0;
                        if (tx_bit_q == 4'd9) begin
                            // End of stop bit: line rests high
                            serial_out_q <= 1'b1;
                            tx_ready_q   <= 1'b1;
                            tx_state_q   <= TX_IDLE;
                        end else begin
                            tx_bit_q     <= tx_bit_q + 4'd1;
                            serial_out_q <= tx_frame_q[1];
                            tx_frame_q   <= {1'b1, tx_frame_q[9:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: begin
                    serial_out_q <= 1'b1;
                    tx_ready_q   <= 1'b1;
                    tx_state_q   <= TX_IDLE;
                end
            endcase
        end
    end

    assign serial_out        = serial_out_q;
    assign bus.data_in_ready = tx_ready_q;

    // ------------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    logic [1:0]       rx_sync_q;
    logic             rx_line;
    rx_state_t        rx_state_q;
    logic [CNT_W-1:0] rx_cnt_q;
    logic [3:0]       rx_bit_q;
    logic [7:0]       rx_shift_q;
    logic [7:0]       rx_shift_d;
    logic             rx_frame_err_q;
    logic [7:0]       data_out_q;
    logic             data_out_valid_q;

    // Two-stage synchronizer; resets to the idle (high) line level
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync_q <= 2'b11;
        end else begin
            rx_sync_q <= {rx_sync_q[0], serial_in};
        end
    end

    assign rx_line    = rx_sync_q[1];
    assign rx_shift_d = {rx_line, rx_shift_q[7:1]};

    // RX FSM plus output handshake; a completing byte overrides a same-edge
    // consumption so the newest byte is never dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q       <= RX_IDLE;
            rx_cnt_q         <= '0;
            rx_bit_q         <= '0;
            rx_shift_q       <= '0;
            rx_frame_err_q   <= 1'b0;
            data_out_q       <= '0;
            data_out_valid_q <= 1'b0;
        end else begin
            if (data_out_valid_q && bus.data_out_ready) begin
                data_out_valid_q <= 1'b0;
            end

            case (rx_state_q)
                RX_IDLE: begin
                    rx_cnt_q       <= '0;
                    rx_frame_err_q <= 1'b0;
                    if (!rx_line) begin
                        rx_bit_q   <= '0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_cnt_q == HALF_LAST) begin
                        rx_cnt_q   <= '0;
                        // High at mid start bit means it was only a glitch
                        rx_state_q <= rx_line ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q   <= '0;
                        rx_shift_q <= rx_shift_d;
                        rx_bit_q   <= rx_bit_q + 4'd1;
                        if (rx_bit_q == 4'd7) begin
                            rx_state_q <= RX_STOP;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_frame_err_q) begin
                        // Framing error: hold off until the line is idle again
                        if (rx_line) begin
                            rx_frame_err_q <= 1'b0;
                            rx_state_q     <= RX_IDLE;
                        end
                    end else if (rx_cnt_q == BIT_LAST) begin
                        rx_cnt_q <= '0;
                        if (rx_line) begin
                            data_out_q       <= rx_shift_q;
                            data_out_valid_q <= 1'b1;
                            rx_state_q       <= RX_IDLE;
                        end else begin
                            rx_frame_err_q <= 1'b1;
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 1'b1;
                    end
                end
                default: begin
                    rx_state_q <= RX_IDLE;
                end
            endcase
        end
    end

    assign bus.data_out       = data_out_q;
    assign bus.data_out_valid = data_out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_transceiver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_transceiver
//  Description : Directed self-checking bench for uart_transceiver, run with
//                a short bit period (20 clocks per bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_transceiver;

    localparam int CLOCK_FREQ = 2_000_000;
    localparam int BAUD_RATE  = 100_000;
    localparam int SEB        = 20;   // clocks per bit
    localparam int HALF       = 10;   // mid-bit offset
    localparam int FRAME      = 10 * SEB;

    localparam logic [7:0] MSG [14] = '{8'h6A, 8'h61, 8'h6C, 8'h20, 8'h31,
                                        8'h30, 8'h30, 8'h30, 8'h30, 8'h30,
                                        8'h30, 8'h30, 8'h0D, 8'h71};

    logic clk     = 1'b0;
    logic reset   = 1'b0;
    logic tb_rx   = 1'b1;
    logic loop_en = 1'b0;
    logic serial_out;
    wire  serial_in_w;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] rxq [$];
    int         valid_rises = 0;
    logic       prev_valid  = 1'b0;

    uart_transceiver_if u_if ();

    uart_transceiver #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (u_if),
        .serial_in  (serial_in_w),
        .serial_out (serial_out)
    );

    assign serial_in_w = loop_en ? serial_out : tb_rx;

    always #5 clk = ~clk;

    // Receive monitor: logs consumed bytes and counts valid pulses
    always @(negedge clk) begin
        if (u_if.data_out_valid && u_if.data_out_ready) rxq.push_back(u_if.data_out);
        if (u_if.data_out_valid && !prev_valid) valid_rises++;
        prev_valid = u_if.data_out_valid;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Offer one byte, then wait (bounded) for the transmitter to finish;
    // returns the number of cycles data_in_ready was low.
    task automatic tx_byte(input logic [7:0] b, output int low_cycles);
        int guard;
        guard = 0;
        while (!u_if.data_in_ready && guard < 2 * FRAME) begin tick(); guard++; end
        u_if.data_in       = b;
        u_if.data_in_valid = 1'b1;
        tick();
        u_if.data_in_valid = 1'b0;
        low_cycles = 0;
        while (!u_if.data_in_ready && low_cycles < 2 * FRAME) begin
            low_cycles++;
            tick();
        end
    endtask

    // Drive one 8N1 frame on serial_in from the bench; flags any valid seen
    task automatic rx_frame(input logic [7:0] b, input logic stop_bit, output logic saw_valid);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        saw_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tb_rx = fr[k];
            for (int c = 0; c < SEB; c++) begin
                tick();
                if (u_if.data_out_valid) saw_valid = 1'b1;
            end
        end
        tb_rx = 1'b1;
    endtask

    task automatic test_reset();
        reset                = 1'b0;
        tb_rx                = 1'b1;
        u_if.data_in         = 8'h00;
        u_if.data_in_valid   = 1'b0;
        u_if.data_out_ready  = 1'b0;
        tick_n(3);
        n_total++; if (serial_out !== 1'b1) $display("FAIL rst_serial_out: got %b want 1", serial_out); else n_pass++;
        n_total++; if (u_if.data_in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", u_if.data_in_ready); else n_pass++;
        n_total++; if (u_if.data_out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", u_if.data_out_valid); else n_pass++;
        n_total++; if (u_if.data_out !== 8'h00) $display("FAIL rst_data_out: got %h want 00", u_if.data_out); else n_pass++;
        reset = 1'b1;
        tick_n(2 * SEB);
        n_total++; if (serial_out !== 1'b1) $display("FAIL rel_serial_out: got %b want 1", serial_out); else n_pass++;
        n_total++; if (u_if.data_in_ready !== 1'b1) $display("FAIL rel_in_ready: got %b want 1", u_if.data_in_ready); else n_pass++;
        n_total++; if (u_if.data_out_valid !== 1'b0) $display("FAIL rel_out_valid: got %b want 0", u_if.data_out_valid); else n_pass++;
        n_total++; if (u_if.data_out !== 8'h00) $display("FAIL rel_data_out: got %h want 00", u_if.data_out); else n_pass++;
    endtask

    task automatic test_loopback();
        logic [9:0] frame;
        int low, first_valid, idx;
        loop_en = 1'b1;
        u_if.data_out_ready = 1'b0;
        frame = 10'b1_0110_1010_0;   // stop, 0x6A, start
        u_if.data_in       = 8'h6A;
        u_if.data_in_valid = 1'b1;
        tick();
        u_if.data_in_valid = 1'b0;
        low = 0;
        first_valid = -1;
        for (int c = 0; c < 12 * SEB; c++) begin
            idx = c / SEB;
            if ((c % SEB) == HALF && idx < 10) begin
                n_total++;
                if (serial_out !== frame[idx]) $display("FAIL lb_bit%0d: got %b want %b", idx, serial_out, frame[idx]);
                else n_pass++;
            end
            if (!u_if.data_in_ready) low++;
            if (u_if.data_out_valid && first_valid < 0) first_valid = c;
            tick();
        end
        n_total++; if (low !== FRAME) $display("FAIL lb_ready_low: got %0d want %0d", low, FRAME); else n_pass++;
        n_total++;
        if (!(first_valid >= 9 * SEB && first_valid < FRAME))
            $display("FAIL lb_valid_time: got %0d want in [%0d,%0d)", first_valid, 9 * SEB, FRAME);
        else n_pass++;
        n_total++; if (u_if.data_out !== 8'h6A) $display("FAIL lb_data_out: got %h want 6a", u_if.data_out); else n_pass++;
        n_total++; if (u_if.data_out_valid !== 1'b1) $display("FAIL lb_valid: got %b want 1", u_if.data_out_valid); else n_pass++;
        u_if.data_out_ready = 1'b1;
        tick();
        u_if.data_out_ready = 1'b0;
        n_total++; if (u_if.data_out_valid !== 1'b0) $display("FAIL lb_consume: got %b want 0", u_if.data_out_valid); else n_pass++;
    endtask

    task automatic test_stream();
        int low, bad_low;
        logic [7:0] got;
        loop_en = 1'b1;
        u_if.data_out_ready = 1'b1;
        tick_n(2);
        rxq.delete();
        valid_rises = 0;
        bad_low = 0;
        for (int i = 0; i < 14; i++) begin
            tx_byte(MSG[i], low);
            if (low != FRAME) bad_low++;
        end
        tick_n(2 * SEB);
        n_total++; if (bad_low !== 0) $display("FAIL st_ready_low: got %0d bad frames want 0", bad_low); else n_pass++;
        n_total++; if (rxq.size() !== 14) $display("FAIL st_count: got %0d want 14", rxq.size()); else n_pass++;
        n_total++; if (valid_rises !== 14) $display("FAIL st_pulses: got %0d want 14", valid_rises); else n_pass++;
        for (int i = 0; i < 14; i++) begin
            got = (i < rxq.size()) ? rxq[i] : 8'hxx;
            n_total++;
            if (got !== MSG[i]) $display("FAIL st_byte%0d: got %h want %h", i, got, MSG[i]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        int low;
        loop_en = 1'b1;
        u_if.data_out_ready = 1'b0;
        tx_byte(8'h61, low);
        tx_byte(8'h6C, low);
        tick_n(SEB);
        n_total++; if (u_if.data_out_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", u_if.data_out_valid); else n_pass++;
        n_total++; if (u_if.data_out !== 8'h6C) $display("FAIL bp_data: got %h want 6c", u_if.data_out); else n_pass++;
        u_if.data_out_ready = 1'b1;
        tick();
        u_if.data_out_ready = 1'b0;
        n_total++; if (u_if.data_out_valid !== 1'b0) $display("FAIL bp_consume: got %b want 0", u_if.data_out_valid); else n_pass++;
    endtask

    task automatic test_noise();
        logic saw;
        loop_en = 1'b0;
        tb_rx = 1'b1;
        tick_n(SEB);
        tb_rx = 1'b0;
        tick_n(4);
        tb_rx = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 12 * SEB; c++) begin
            tick();
            if (u_if.data_out_valid) saw = 1'b1;
        end
        n_total++; if (saw !== 1'b0) $display("FAIL noise_valid: got %b want 0", saw); else n_pass++;
        n_total++; if (u_if.data_out !== 8'h6C) $display("FAIL noise_data: got %h want 6c", u_if.data_out); else n_pass++;
    endtask

    task automatic test_framing();
        logic saw;
        loop_en = 1'b0;
        u_if.data_out_ready = 1'b0;
        rx_frame(8'hA3, 1'b0, saw);
        for (int c = 0; c < 2 * SEB; c++) begin
            tick();
            if (u_if.data_out_valid) saw = 1'b1;
        end
        n_total++; if (saw !== 1'b0) $display("FAIL fe_valid: got %b want 0", saw); else n_pass++;
        n_total++; if (u_if.data_out !== 8'h6C) $display("FAIL fe_data_kept: got %h want 6c", u_if.data_out); else n_pass++;
        rx_frame(8'h55, 1'b1, saw);
        tick_n(SEB);
        n_total++; if (u_if.data_out_valid !== 1'b1) $display("FAIL fe_next_valid: got %b want 1", u_if.data_out_valid); else n_pass++;
        n_total++; if (u_if.data_out !== 8'h55) $display("FAIL fe_next_data: got %h want 55", u_if.data_out); else n_pass++;
    endtask

    task automatic test_reset_mid_tx();
        logic saw_low;
        loop_en = 1'b0;
        tb_rx = 1'b1;
        u_if.data_in       = 8'h00;
        u_if.data_in_valid = 1'b1;
        tick();
        u_if.data_in_valid = 1'b0;
        tick_n(3 * SEB + 3);
        n_total++; if (serial_out !== 1'b0) $display("FAIL mr_pre_line: got %b want 0", serial_out); else n_pass++;
        n_total++; if (u_if.data_in_ready !== 1'b0) $display("FAIL mr_pre_ready: got %b want 0", u_if.data_in_ready); else n_pass++;
        #2;
        reset = 1'b0;
        #1;
        n_total++; if (serial_out !== 1'b1) $display("FAIL mr_line: got %b want 1", serial_out); else n_pass++;
        n_total++; if (u_if.data_in_ready !== 1'b1) $display("FAIL mr_ready: got %b want 1", u_if.data_in_ready); else n_pass++;
        n_total++; if (u_if.data_out_valid !== 1'b0) $display("FAIL mr_out_valid: got %b want 0", u_if.data_out_valid); else n_pass++;
        n_total++; if (u_if.data_out !== 8'h00) $display("FAIL mr_data_out: got %h want 00", u_if.data_out); else n_pass++;
        tick_n(2);
        reset = 1'b1;
        saw_low = 1'b0;
        for (int c = 0; c < 2 * SEB; c++) begin
            tick();
            if (!serial_out) saw_low = 1'b1;
        end
        n_total++; if (saw_low !== 1'b0) $display("FAIL mr_line_idle: got %b want 0", saw_low); else n_pass++;
        n_total++; if (u_if.data_in_ready !== 1'b1) $display("FAIL mr_ready_idle: got %b want 1", u_if.data_in_ready); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_stream();
        test_backpressure();
        test_noise();
        test_framing();
        test_reset_mid_tx();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_transceiver.md
Name: uart_transceiver

Overview:
- Full-duplex 8N1 UART with byte-wide ready/valid interfaces on both the transmit and receive paths.
- Used as the on-chip serial port of the CPU top level.
- Also used as the off-chip reference UART in system benches, with its serial_out/serial_in cross-connected to the FPGA serial pins.
- Transmitter and receiver are independent and may operate simultaneously.

Parameters:
- CLOCK_FREQ, 125_000_000: clk frequency in Hz.
- BAUD_RATE, 115_200: serial bit rate.
- Derived: SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE (integer divide; 1085 at defaults), clocks per bit.
- Derived: SAMPLE_TIME = SYMBOL_EDGE_TIME / 2 (542), mid-bit sample offset.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_in  input  8  byte to transmit.
- data_in_valid  input  1  data_in is offered.
- data_in_ready  output  1  transmitter idle, can accept a byte.
- data_out  output  8  last received byte.
- data_out_valid  output  1  data_out holds an unconsumed byte.
- data_out_ready  input  1  consumer accepts data_out.
- serial_in  input  1  RX line, idle high.
- serial_out  output  1  TX line, idle high.

Behaviour:

Reset (reset=0, takes effect immediately, independent of clk):
- serial_out=1, data_in_ready=1, data_out_valid=0, data_out=0.
- Both FSMs go to IDLE and all counters clear.
- A reset mid-frame aborts the frame: serial_out returns high at once, and no partial RX byte is delivered.

Transmitter:
- FSM states: IDLE, SEND.
- data_in_ready = 1 only in IDLE.
- On a rising edge with data_in_valid & data_in_ready:
  - Latch the 10-bit frame {1, data_in[7:0], 0}.
  - Enter SEND and drop data_in_ready.
- From the next cycle, serial_out drives the start bit (0), then data bits LSB first, then the stop bit (1). Each bit is held exactly SYMBOL_EDGE_TIME cycles.
- Total frame length is 10*SYMBOL_EDGE_TIME cycles. At the end of the stop bit the FSM returns to IDLE and data_in_ready rises.
- data_in and data_in_valid are ignored while not ready. No internal queue.
- serial_out is driven from a register (glitch-free).

Receiver:
- serial_in passes through a 2-flop synchronizer (flops reset to 1) before use.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: a synchronized 0 enters START and clears the bit counter.
- START: after SAMPLE_TIME cycles, sample the line.
  - If 1 (glitch shorter than half a bit), return to IDLE with no output.
  - Else go to DATA.
- DATA: sample every SYMBOL_EDGE_TIME cycles, mid-bit. Shift in LSB first; 8 samples.
- STOP: sample once more after SYMBOL_EDGE_TIME.
  - If 1: load data_out with the byte and set data_out_valid on the next edge.
  - If 0 (framing error): discard the byte, leave data_out_valid unchanged, wait for the line to return high, then go to IDLE.
- After STOP the FSM re-arms in IDLE, so back-to-back frames are received.

Receive handshake:
- data_out_valid clears on a rising edge with data_out_valid & data_out_ready.
- data_out is stable while data_out_valid=1.
- If a new valid byte completes while data_out_valid is still 1, data_out is overwritten with the newer byte and data_out_valid stays 1. The older byte is lost; there is no overrun flag.
- If completion and consumption land on the same edge, the new byte wins: data_out = new byte, data_out_valid = 1.

Counters and widths:
- The clock counter is wide enough for SYMBOL_EDGE_TIME-1, i.e. $clog2(SYMBOL_EDGE_TIME).
- The counter wraps to 0 at each bit boundary.
- Bit counters are 4 bits.

Test Plan:
- Reset: hold reset=0 with serial_in=1 -> serial_out=1, data_in_ready=1, data_out_valid=0. Release -> all unchanged.
- Loopback TX->RX (serial_out tied to serial_in), send 0x6A:
  - data_in_ready low for 10850 cycles.
  - serial_out shows 0,0,1,0,1,0,1,1,0,1 per 1085-cycle bit.
  - data_out=0x6A with data_out_valid=1 about 9.5 bit times after the start edge.
- Stream "jal 10000000\r" then "q" (0x6A 0x61 0x6C 0x20 0x31 0x30×7 0x0D 0x71) in loopback, with data_out_ready=1 -> each byte received in order, one valid pulse per byte.
- Backpressure: data_out_ready=0, receive 0x61 then 0x6C -> data_out_valid stays 1 and data_out=0x6C. Raise data_out_ready for one cycle -> data_out_valid=0.
- Noise: 200-cycle low glitch on serial_in -> no data_out_valid.
- Framing error: frame with stop bit 0 -> no data_out_valid; the next good frame 0x55 is still received.
- Reset asserted mid-TX frame -> serial_out=1 immediately and data_in_ready=1.
